// File: rtl/mux_4_1_arbiter.sv
// mux_4_1_arbiter: round-robin req/grant arbiter with hold timer sharing a 4:1 single-bit mux.
module mux_4_1 (
    input  logic in0,
    input  logic in1,
    input  logic in2,
    input  logic in3,
    input  logic sel0,
    input  logic sel1,
    output logic out
);
    assign out = sel1 ? (sel0 ? in3 : in2) : (sel0 ? in1 : in0);
endmodule

module mux_4_1_arbiter #(
    parameter int HOLD_MAX = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    input  logic       in0,
    input  logic       in1,
    input  logic       in2,
    input  logic       in3,
    output logic [3:0] grant,
    output logic       sel0,
    output logic       sel1,
    output logic       busy,
    output logic       out
);
    localparam int CW = $clog2(HOLD_MAX);
    localparam logic IDLE = 1'b0;
    localparam logic GRANT = 1'b1;
    logic          state;
    logic [1:0]    owner;
    logic [1:0]    ptr;
    logic [CW-1:0] cnt;
    logic [1:0]    pick;
    logic [3:0]    others;
    logic          last;
    logic          take;
    logic          mux_out;
    // Descending scan so the smallest offset from ptr wins.
    always_comb begin
        pick = ptr;
        for (int i = 3; i >= 0; i--) begin
            if (req[2'(ptr + 2'(i))]) pick = 2'(ptr + 2'(i));
        end
    end
    assign others = req & ~(4'b0001 << owner);
    assign last   = cnt == CW'(HOLD_MAX - 1);
    assign take   = (state == IDLE || !req[owner]) ? |req : (last && |others);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            owner <= '0;
            ptr   <= '0;
            cnt   <= '0;
            grant <= '0;
            busy  <= 1'b0;
        end else if (take) begin
            state <= GRANT;
            owner <= pick;
            ptr   <= pick + 2'd1;
            cnt   <= '0;
            grant <= 4'b0001 << pick;
            busy  <= 1'b1;
        end else if (state == GRANT && !req[owner]) begin
            state <= IDLE;
            grant <= '0;
            busy  <= 1'b0;
        end else if (state == GRANT) begin
            cnt <= last ? '0 : cnt + 1'b1;
        end
    end
    assign sel0 = owner[0];
    assign sel1 = owner[1];
    mux_4_1 u_mux (
        .in0 (in0),
        .in1 (in1),
        .in2 (in2),
        .in3 (in3),
        .sel0(sel0),
        .sel1(sel1),
        .out (mux_out)
    );
    assign out = busy & mux_out;
endmodule

// File: tb/tb_mux_4_1_arbiter.sv
// tb_mux_4_1_arbiter: directed vector table plus hand sequences for contention and async reset.
module tb_mux_4_1_arbiter;
    typedef struct packed {
        logic [3:0] req;
        logic [3:0] in;
        logic [3:0] grant;
        logic       busy;
        logic [1:0] sel;
        logic       out;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] req = '0;
    logic [3:0] din = '0;
    logic [3:0] grant;
    logic       sel0, sel1, busy, out;
    int         n_checks = 0;
    int         n_fail = 0;
    vec_t       tv[23];

    always #5 clk = ~clk;

    mux_4_1_arbiter #(.HOLD_MAX(4)) dut (
        .clk  (clk),
        .reset(reset),
        .req  (req),
        .in0  (din[0]),
        .in1  (din[1]),
        .in2  (din[2]),
        .in3  (din[3]),
        .grant(grant),
        .sel0 (sel0),
        .sel1 (sel1),
        .busy (busy),
        .out  (out)
    );

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_all(input string name, input logic [3:0] g, input logic b,
                             input logic [1:0] s, input logic o);
        check({name, ".grant"}, grant, g);
        check({name, ".busy"}, {3'b0, busy}, {3'b0, b});
        check({name, ".sel"}, {2'b0, sel1, sel0}, {2'b0, s});
        check({name, ".out"}, {3'b0, out}, {3'b0, o});
    endtask

    initial begin
        tv[0] = '{4'b0100, 4'b0100, 4'b0100, 1'b1, 2'd2, 1'b1};
        tv[1] = '{4'b0100, 4'b0000, 4'b0100, 1'b1, 2'd2, 1'b0};
        tv[2] = '{4'b0100, 4'b0100, 4'b0100, 1'b1, 2'd2, 1'b1};
        tv[3] = '{4'b0000, 4'b0100, 4'b0000, 1'b0, 2'd2, 1'b0};
        for (int i = 4; i < 7; i++) tv[i] = '{4'b0000, 4'b1111, 4'b0000, 1'b0, 2'd2, 1'b0};
        tv[7]  = '{4'b0101, 4'b0001, 4'b0001, 1'b1, 2'd0, 1'b1};
        tv[8]  = '{4'b0011, 4'b0000, 4'b0001, 1'b1, 2'd0, 1'b0};
        tv[9]  = '{4'b0011, 4'b0001, 4'b0001, 1'b1, 2'd0, 1'b1};
        tv[10] = '{4'b0010, 4'b0010, 4'b0010, 1'b1, 2'd1, 1'b1};
        tv[11] = '{4'b0000, 4'b1111, 4'b0000, 1'b0, 2'd1, 1'b0};
        for (int i = 12; i < 22; i++) tv[i] = '{4'b1000, 4'b1000, 4'b1000, 1'b1, 2'd3, 1'b1};
        tv[22] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd3, 1'b0};

        repeat (2) @(negedge clk);
        check_all("reset", 4'b0000, 1'b0, 2'd0, 1'b0);
        reset = 1'b0;
        for (int i = 0; i < 23; i++) begin
            @(negedge clk);
            req = tv[i].req;
            din = tv[i].in;
            @(posedge clk);
            #1;
            check_all($sformatf("vec%0d", i), tv[i].grant, tv[i].busy, tv[i].sel, tv[i].out);
        end

        @(negedge clk);
        reset = 1'b1;
        req = 4'b1111;
        din = 4'b1111;
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            check_all($sformatf("rr%0d", k), 4'b0001 << ((k / 4) % 4), 1'b1, 2'((k / 4) % 4), 1'b1);
        end

        @(negedge clk);
        req = 4'b0000;
        @(negedge clk);
        req = 4'b1000;
        din = 4'b1000;
        @(posedge clk);
        #1;
        check_all("own3", 4'b1000, 1'b1, 2'd3, 1'b1);
        #1 din = 4'b0000;
        #1 check("comb_out_lo", {3'b0, out}, 4'b0000);
        din = 4'b1000;
        #1 check("comb_out_hi", {3'b0, out}, 4'b0001);
        reset = 1'b1;
        #1 check_all("async_rst", 4'b0000, 1'b0, 2'd0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        req = 4'b1111;
        din = 4'b0001;
        @(posedge clk);
        #1;
        check_all("post_rst", 4'b0001, 1'b1, 2'd0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
